// File: rtl/sram_arb.sv
// -----------------------------------------------------------------------------
// sram_arb
//   Two-master arbiter in front of a pair of 8192 x 32 single-port SRAM banks.
//   Arbitration is combinational: the winning access is driven onto the SRAM
//   pins in the same cycle its grant is raised. A master holding mN_lock keeps
//   ownership across consecutive accesses (burst). Reads return one cycle after
//   the grant, with disabled bytes forced to zero.
//
//   Build option:
//     SRAM_ARB_RR_EN  defined   -> round-robin tie-break in IDLE
//                     undefined -> fixed priority, m0 wins ties
//
// Ports
//   hclk, hreset                 clock, async active-low reset
//   mN_req/lock/write            request, burst lock, 1=write (N = 0,1)
//   mN_addr[13:0]                [13]=bank, [12:0]=row
//   mN_be[3:0], mN_wdata[31:0]   byte enables (active-high), write data
//   mN_gnt                       access issued this cycle
//   mN_rvalid, mN_rdata[31:0]    read return, data held while rvalid=0
//   bank0_cen, bank1_cen[3:0]    per-byte chip enables, active-low
//   sram_w_en                    write enable, active-low
//   sram_addr[12:0], sram_data   row address and write data
//   sram_q0..sram_q7[7:0]        read bytes, q0-q3 bank0, q4-q7 bank1
// -----------------------------------------------------------------------------
module sram_arb (
  input  logic        hclk,
  input  logic        hreset,

  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_write,
  input  logic [13:0] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_write,
  input  logic [13:0] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,

  output logic [3:0]  bank0_cen,
  output logic [3:0]  bank1_cen,
  output logic        sram_w_en,
  output logic [12:0] sram_addr,
  output logic [31:0] sram_data,

  input  logic [7:0]  sram_q0,
  input  logic [7:0]  sram_q1,
  input  logic [7:0]  sram_q2,
  input  logic [7:0]  sram_q3,
  input  logic [7:0]  sram_q4,
  input  logic [7:0]  sram_q5,
  input  logic [7:0]  sram_q6,
  input  logic [7:0]  sram_q7
);

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned ROW_W  = 13;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned BANK_B = ADDR_W - 1;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q, state_d;

  acc_t acc0, acc1, win;
  logic gnt0_raw, gnt1_raw;
  logic any_gnt;
  logic tie_m1;
  logic rd_issue;

  logic              rvalid0_q, rvalid1_q;
  logic              bank_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] hold0_q, hold1_q;
  logic [DATA_W-1:0] rd_word, rd_data;

  assign acc0 = {m0_write, m0_addr, m0_be, m0_wdata};
  assign acc1 = {m1_write, m1_addr, m1_be, m1_wdata};

  // Tie-break selector for IDLE when both masters request
`ifdef SRAM_ARB_RR_EN
  logic rr_q;  // 1 = favour m1 on the next tie

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      rr_q <= 1'b0;
    end else if (gnt0_raw) begin
      rr_q <= 1'b1;
    end else if (gnt1_raw) begin
      rr_q <= 1'b0;
    end
  end

  assign tie_m1 = rr_q;
`else
  assign tie_m1 = 1'b0;
`endif

  // Ownership state register
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant selection and ownership transitions
  always_comb begin
    state_d  = state_q;
    gnt0_raw = 1'b0;
    gnt1_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          gnt0_raw = !tie_m1;
          gnt1_raw = tie_m1;
        end else begin
          gnt0_raw = m0_req;
          gnt1_raw = m1_req;
        end
        if (gnt0_raw && m0_lock) begin
          state_d = OWN0;
        end else if (gnt1_raw && m1_lock) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        // The other master waits for as long as the burst lasts.
        gnt0_raw = m0_req;
        if (!m0_req || !m0_lock) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        gnt1_raw = m1_req;
        if (!m1_req || !m1_lock) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Visible grants are suppressed while reset is held; internal flops are
  // already held in reset, so they take the raw grant.
  assign m0_gnt  = gnt0_raw & hreset;
  assign m1_gnt  = gnt1_raw & hreset;
  assign any_gnt = m0_gnt | m1_gnt;
  assign win     = gnt1_raw ? acc1 : acc0;

  // SRAM pin drive: winner's access, or an all-quiet bus
  always_comb begin
    bank0_cen = 4'hF;
    bank1_cen = 4'hF;
    sram_w_en = 1'b1;
    sram_addr = '0;
    sram_data = '0;
    if (any_gnt) begin
      if (win.addr[BANK_B]) begin
        bank1_cen = ~win.be;
      end else begin
        bank0_cen = ~win.be;
      end
      sram_w_en = ~win.write;
      sram_addr = win.addr[ROW_W-1:0];
      sram_data = win.wdata;
    end
  end

  assign rd_issue = (gnt0_raw & ~m0_write) | (gnt1_raw & ~m1_write);

  // Read pipeline: remember who asked, which bank and which bytes
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      bank_q    <= 1'b0;
      be_q      <= '0;
    end else begin
      rvalid0_q <= gnt0_raw & ~m0_write;
      rvalid1_q <= gnt1_raw & ~m1_write;
      if (rd_issue) begin
        bank_q <= win.addr[BANK_B];
        be_q   <= win.be;
      end
    end
  end

  // Bank select and byte masking of the returning SRAM word
  always_comb begin
    rd_word = bank_q ? {sram_q7, sram_q6, sram_q5, sram_q4}
                     : {sram_q3, sram_q2, sram_q1, sram_q0};
    rd_data = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (be_q[i]) begin
        rd_data[8*i +: 8] = rd_word[8*i +: 8];
      end
    end
  end

  // Last returned word per master, presented while rvalid is low
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      if (rvalid0_q) begin
        hold0_q <= rd_data;
      end
      if (rvalid1_q) begin
        hold1_q <= rd_data;
      end
    end
  end

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rvalid0_q ? rd_data : hold0_q;
  assign m1_rdata  = rvalid1_q ? rd_data : hold1_q;

endmodule

// File: tb/tb_sram_arb.sv
// -----------------------------------------------------------------------------
// tb_sram_arb
//   Directed bench for sram_arb with a behavioural two-bank SRAM behind it.
//   Expected read data is pushed to a queue at the grant and popped when the
//   return is due. Inputs are driven 1 ns after the rising edge and outputs are
//   sampled 3 ns after it.
// -----------------------------------------------------------------------------
module tb_sram_arb;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;

  logic        m0_req, m0_lock, m0_write;
  logic [13:0] m0_addr;
  logic [3:0]  m0_be;
  logic [31:0] m0_wdata;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req, m1_lock, m1_write;
  logic [13:0] m1_addr;
  logic [3:0]  m1_be;
  logic [31:0] m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;

  logic [3:0]  bank0_cen, bank1_cen;
  logic        sram_w_en;
  logic [12:0] sram_addr;
  logic [31:0] sram_data;
  logic [7:0]  sram_q0, sram_q1, sram_q2, sram_q3;
  logic [7:0]  sram_q4, sram_q5, sram_q6, sram_q7;

  always #5 hclk = ~hclk;

  sram_arb dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .m0_req    (m0_req),
    .m0_lock   (m0_lock),
    .m0_write  (m0_write),
    .m0_addr   (m0_addr),
    .m0_be     (m0_be),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_lock   (m1_lock),
    .m1_write  (m1_write),
    .m1_addr   (m1_addr),
    .m1_be     (m1_be),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .bank0_cen (bank0_cen),
    .bank1_cen (bank1_cen),
    .sram_w_en (sram_w_en),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_q0   (sram_q0),
    .sram_q1   (sram_q1),
    .sram_q2   (sram_q2),
    .sram_q3   (sram_q3),
    .sram_q4   (sram_q4),
    .sram_q5   (sram_q5),
    .sram_q6   (sram_q6),
    .sram_q7   (sram_q7)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  en);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // Behavioural synchronous SRAM banks
  logic [31:0] mem0 [0:8191];
  logic [31:0] mem1 [0:8191];
  logic [31:0] q0w, q1w;

  always @(posedge hclk) begin
    if (bank0_cen != 4'hF) begin
      if (!sram_w_en) mem0[sram_addr] <= merge(mem0[sram_addr], sram_data, ~bank0_cen);
      else            q0w <= merge(q0w, mem0[sram_addr], ~bank0_cen);
    end
    if (bank1_cen != 4'hF) begin
      if (!sram_w_en) mem1[sram_addr] <= merge(mem1[sram_addr], sram_data, ~bank1_cen);
      else            q1w <= merge(q1w, mem1[sram_addr], ~bank1_cen);
    end
  end

  assign {sram_q3, sram_q2, sram_q1, sram_q0} = q0w;
  assign {sram_q7, sram_q6, sram_q5, sram_q4} = q1w;

  typedef struct {
    logic        m;
    logic [31:0] d;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] exp_mem [logic [13:0]];
  logic        exp_rv0 = 1'b0;
  logic        exp_rv1 = 1'b0;
  logic [31:0] last_rd0 = '0;
  logic [31:0] last_rd1 = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [13:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
  endfunction

  task automatic idle_inputs();
    m0_req = 1'b0; m0_lock = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_lock = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
  endtask

  // One cycle: check grants, pins and returns, update model, advance clock
  task automatic step(input logic eg0, input logic eg1, input string tag);
    logic        w;
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [3:0]  ec0, ec1;
    logic        ew;
    logic [12:0] ea;
    logic [31:0] ed;
    exp_t        e;
    #2;
    chk({tag, " m0_gnt"}, 32'(m0_gnt), 32'(eg0));
    chk({tag, " m1_gnt"}, 32'(m1_gnt), 32'(eg1));
    if (eg1) begin
      w = m1_write; a = m1_addr; be = m1_be; d = m1_wdata;
    end else begin
      w = m0_write; a = m0_addr; be = m0_be; d = m0_wdata;
    end
    ec0 = 4'hF; ec1 = 4'hF; ew = 1'b1; ea = '0; ed = '0;
    if (eg0 || eg1) begin
      if (a[13]) ec1 = ~be;
      else       ec0 = ~be;
      ew = ~w; ea = a[12:0]; ed = d;
    end
    chk({tag, " bank0_cen"}, 32'(bank0_cen), 32'(ec0));
    chk({tag, " bank1_cen"}, 32'(bank1_cen), 32'(ec1));
    chk({tag, " sram_w_en"}, 32'(sram_w_en), 32'(ew));
    chk({tag, " sram_addr"}, 32'(sram_addr), 32'(ea));
    chk({tag, " sram_data"}, sram_data, ed);
    chk({tag, " m0_rvalid"}, 32'(m0_rvalid), 32'(exp_rv0));
    chk({tag, " m1_rvalid"}, 32'(m1_rvalid), 32'(exp_rv1));
    if (exp_rv0 || exp_rv1) begin
      if (sb.size() == 0) begin
        chk({tag, " sb_underflow"}, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, " sb_master"}, 32'(e.m), 32'(exp_rv1));
        if (e.m) last_rd1 = e.d;
        else     last_rd0 = e.d;
      end
    end
    chk({tag, " m0_rdata"}, m0_rdata, last_rd0);
    chk({tag, " m1_rdata"}, m1_rdata, last_rd1);
    if (eg0 || eg1) begin
      if (w) begin
        exp_mem[a] = merge(mem_rd(a), d, be);
      end else begin
        e.m = eg1;
        e.d = merge(32'h0, mem_rd(a), be);
        sb.push_back(e);
      end
    end
    exp_rv0 = eg0 && !m0_write;
    exp_rv1 = eg1 && !m1_write;
    @(posedge hclk);
    #1;
  endtask

  initial begin
    logic t1;
    idle_inputs();
    #1 hreset = 1'b0;
    step(1'b0, 1'b0, "reset0");
    step(1'b0, 1'b0, "reset1");
    hreset = 1'b1;

    // Fill words through the arbiter
    m0_req = 1'b1; m0_write = 1'b1; m0_addr = 14'h0010; m0_be = 4'hF; m0_wdata = 32'h4433_2211;
    step(1'b1, 1'b0, "wr_0010");
    m0_addr = 14'h2005; m0_wdata = 32'hDEAD_BEEF;
    step(1'b1, 1'b0, "wr_2005_full");
    m0_be = 4'h3; m0_wdata = 32'hA5A5_1234;
    step(1'b1, 1'b0, "wr_2005_be3");

    // Single read from bank0 by m1
    idle_inputs();
    m1_req = 1'b1; m1_addr = 14'h0010; m1_be = 4'hF;
    step(1'b0, 1'b1, "rd_0010");
    idle_inputs();
    step(1'b0, 1'b1 & 1'b0, "rd_0010_rv");

    // Both request continuously without lock
    m0_req = 1'b1; m0_addr = 14'h2005; m0_be = 4'hF;
    m1_req = 1'b1; m1_addr = 14'h0010; m1_be = 4'h5;
    for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_RR_EN
      t1 = (k % 2) == 1;
`else
      t1 = 1'b0;
`endif
      step(!t1, t1, $sformatf("tie%0d", k));
    end
    idle_inputs();
    step(1'b0, 1'b0, "tie_drain");

    // Read with no byte enables returns zero, no SRAM enable
    m0_req = 1'b1; m0_addr = 14'h0010; m0_be = 4'h0;
    step(1'b1, 1'b0, "rd_be0");
    idle_inputs();
    m1_req = 1'b1; m1_addr = 14'h2005; m1_be = 4'h9;
    step(1'b0, 1'b1, "rd_be9");
    idle_inputs();
    step(1'b0, 1'b0, "rd_be9_rv");

    // m1 locked 4-write burst while m0 waits
    m0_addr = 14'h2102; m0_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      m1_req = 1'b1; m1_write = 1'b1; m1_lock = (i < 3); m1_be = 4'hF;
      m1_addr = 14'h2100 + 14'(i); m1_wdata = 32'h1000_0000 + 32'(i);
      m0_req = (i > 0);
      step(1'b0, 1'b1, $sformatf("burst%0d", i));
    end
    m1_req = 1'b0; m1_write = 1'b0; m1_lock = 1'b0;
    step(1'b1, 1'b0, "burst_m0");
    idle_inputs();
    step(1'b0, 1'b0, "burst_rv");

    // Reset while m0 owns the bus and has a read granted
    m0_req = 1'b1; m0_lock = 1'b1; m0_write = 1'b1; m0_addr = 14'h0020; m0_be = 4'hF;
    m0_wdata = 32'hCAFE_F00D;
    step(1'b1, 1'b0, "own0_wr");
    m0_write = 1'b0;
    m1_req = 1'b1; m1_addr = 14'h0010; m1_be = 4'hF;
    #2;
    chk("own0_rd m0_gnt", 32'(m0_gnt), 32'd1);
    chk("own0_rd m1_gnt", 32'(m1_gnt), 32'd0);
    hreset = 1'b0;
    #1;
    chk("rst_in m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_in m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_in bank0_cen", 32'(bank0_cen), 32'hF);
    chk("rst_in sram_w_en", 32'(sram_w_en), 32'd1);
    exp_rv0 = 1'b0; exp_rv1 = 1'b0; last_rd0 = '0; last_rd1 = '0;
    @(posedge hclk);
    #1;
    step(1'b0, 1'b0, "rst_hold");
    hreset = 1'b1;
    m0_req = 1'b0; m0_lock = 1'b0;
    step(1'b0, 1'b1, "post_rst_m1");
    idle_inputs();
    step(1'b0, 1'b0, "post_rst_rv");
    step(1'b0, 1'b0, "final_idle");

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
